// File: rtl/fpu_mul_pkg.sv
// Shared types and result-formation helper for the FPU_MUL mantissa path.
`timescale 1ns/1ps
package fpu_mul_pkg;

  localparam int MAN_DEFAULT = 24;
  localparam int MAN_MAX     = 53;
  localparam int P_MAX       = 2 * MAN_MAX;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic               norm_shift;
    logic [MAN_MAX-1:0] man;
    logic               guard;
    logic               sticky;
  } grs_t;

  // Normalize a 2s-bit product p (zero-extended to P_MAX) and split it into
  // the kept mantissa, guard bit and sticky OR of everything below guard.
  function automatic grs_t grs_of(input logic [P_MAX-1:0] p, input int s);
    grs_t             r;
    logic [P_MAX-1:0] t;
    logic [P_MAX-1:0] mask;
    r = '0;
    t = p >> (2 * s - 1);
    r.norm_shift = t[0];
    if (r.norm_shift) begin
      r.man   = MAN_MAX'(p >> s);
      t       = p >> (s - 1);
      r.guard = t[0];
      mask    = (P_MAX'(1) << (s - 1)) - P_MAX'(1);
    end else begin
      r.man   = MAN_MAX'(p >> (s - 1));
      t       = p >> (s - 2);
      r.guard = t[0];
      mask    = (P_MAX'(1) << (s - 2)) - P_MAX'(1);
    end
    r.sticky = |(p & mask);
    return r;
  endfunction

endpackage

// File: rtl/mul_man_grs_extract.sv
// Combinational normalize + round-to-nearest-even decision on a full product.
`timescale 1ns/1ps
module mul_man_grs_extract
  import fpu_mul_pkg::*;
#(
  parameter int SIZE_MAN = MAN_DEFAULT
) (
  input  logic [2*SIZE_MAN-1:0] i_p,
  output logic [SIZE_MAN-1:0]   o_man,
  output logic                  o_rounding_bit,
  output logic                  o_norm_shift
);

  grs_t w_grs;

  assign w_grs          = grs_of(P_MAX'(i_p), SIZE_MAN);
  assign o_man          = w_grs.man[SIZE_MAN-1:0];
  assign o_norm_shift   = w_grs.norm_shift;
  // Tie rounds to even: increment only when guard set and either sticky or odd LSB.
  assign o_rounding_bit = w_grs.guard & (w_grs.sticky | w_grs.man[0]);

  // Upper mantissa bits are always zero for narrow configurations.
  if (SIZE_MAN < MAN_MAX) begin : g_pad
    logic w_unused_hi;
    assign w_unused_hi = |w_grs.man[MAN_MAX-1:SIZE_MAN];
  end

endmodule

// File: rtl/mul_man_product_seq.sv
// Radix-2 shift-add mantissa multiplier, one partial product per cycle,
// valid/ready on both sides. Feeds the mantissa rounding stage.
`timescale 1ns/1ps
module mul_man_product_seq
  import fpu_mul_pkg::*;
#(
  parameter int SIZE_MAN = MAN_DEFAULT,
  parameter int SIZE_CNT = $clog2(SIZE_MAN + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [SIZE_MAN-1:0] i_man_a,
  input  logic [SIZE_MAN-1:0] i_man_b,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [SIZE_MAN-1:0] o_man,
  output logic                o_rounding_bit,
  output logic                o_norm_shift
);

  state_t                r_state, w_state_nxt;
  logic [SIZE_MAN-1:0]   r_mcand, r_mplier;
  logic [2*SIZE_MAN-1:0] r_acc, w_acc_nxt, w_addend;
  logic [SIZE_CNT-1:0]   r_cnt;
  logic                  w_ready, w_valid, w_accept, w_last;

  logic [SIZE_MAN-1:0]   r_man, w_man;
  logic                  r_rnd, w_rnd, r_norm, w_norm;

  assign w_addend  = {{SIZE_MAN{1'b0}}, r_mcand} << r_cnt;
  assign w_acc_nxt = r_mplier[0] ? (r_acc + w_addend) : r_acc;
  assign w_last    = (r_cnt == SIZE_CNT'(SIZE_MAN - 1));
  assign w_accept  = i_valid & w_ready;

  // Rounding info is taken from the accumulator value about to be written,
  // so the result registers load on the same edge that enters S_DONE.
  mul_man_grs_extract #(.SIZE_MAN(SIZE_MAN)) u_grs (
    .i_p            (w_acc_nxt),
    .o_man          (w_man),
    .o_rounding_bit (w_rnd),
    .o_norm_shift   (w_norm)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_valid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (i_valid) w_state_nxt = S_CALC;
      end
      S_CALC: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_valid = 1'b1;
        if (i_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ready is forced low while reset is held, even though state reads S_IDLE.
  assign o_ready = w_ready & i_rst_n;
  assign o_valid = w_valid;

  // Operand capture and the iterative shift-add.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand  <= i_man_a;
            r_mplier <= i_man_b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        S_CALC: begin
          r_acc    <= w_acc_nxt;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + SIZE_CNT'(1);
        end
        default: ;
      endcase
    end
  end

  // Result registers load on the final iteration and otherwise hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_man  <= '0;
      r_rnd  <= 1'b0;
      r_norm <= 1'b0;
    end else if (r_state == S_CALC && w_last) begin
      r_man  <= w_man;
      r_rnd  <= w_rnd;
      r_norm <= w_norm;
    end
  end

  assign o_man          = r_man;
  assign o_rounding_bit = r_rnd;
  assign o_norm_shift   = r_norm;

endmodule

// File: tb/tb_mul_man_product_seq.sv
// Scoreboard bench for the sequential mantissa multiplier (SIZE_MAN = 24).
`timescale 1ns/1ps
module tb_mul_man_product_seq;

  localparam int S = 24;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_ready = 1'b0;
  logic [S-1:0] i_man_a = '0;
  logic [S-1:0] i_man_b = '0;
  logic         o_ready, o_valid, o_rounding_bit, o_norm_shift;
  logic [S-1:0] o_man;

  mul_man_product_seq #(.SIZE_MAN(S)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_man_a        (i_man_a),
    .i_man_b        (i_man_b),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_man          (o_man),
    .o_rounding_bit (o_rounding_bit),
    .o_norm_shift   (o_norm_shift)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [S-1:0] man;
    logic         rnd;
    logic         norm;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference: full product, fixed-slice normalization, RNE decision.
  function automatic exp_t model(input logic [S-1:0] a, input logic [S-1:0] b);
    logic [2*S-1:0] p;
    logic           g, st;
    exp_t           e;
    p = {{S{1'b0}}, a} * {{S{1'b0}}, b};
    if (p[2*S-1]) begin
      e.norm = 1'b1; e.man = p[2*S-1:S];   g = p[S-1]; st = |p[S-2:0];
    end else begin
      e.norm = 1'b0; e.man = p[2*S-2:S-1]; g = p[S-2]; st = |p[S-3:0];
    end
    e.rnd = g & (st | e.man[0]);
    return e;
  endfunction

  // Present operands and complete the input handshake; returns #1 after the edge.
  task automatic send_op(input logic [S-1:0] a, input logic [S-1:0] b);
    int w;
    @(negedge i_clk);
    i_man_a = a; i_man_b = b; i_valid = 1'b1;
    w = 0;
    while (!o_ready && w < 100) begin @(negedge i_clk); w++; end
    n_tests++;
    if (o_ready !== 1'b1) begin
      n_fail++; $display("FAIL send_ready: o_ready=%b required 1", o_ready);
    end
    sb.push_back(model(a, b));
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  // Called just after acceptance; counts cycles to o_valid and checks the result.
  task automatic wait_result(input string name, output int cyc);
    exp_t e;
    cyc = 1;
    @(negedge i_clk);
    while (!o_valid && cyc < 200) begin @(posedge i_clk); cyc++; @(negedge i_clk); end
    n_tests++;
    if (o_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s_timeout: o_valid=%b required 1", name, o_valid);
    end
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL %s_sb: scoreboard size 0 required 1", name);
    end else begin
      e = sb.pop_front();
      if ({o_man, o_rounding_bit, o_norm_shift} !== {e.man, e.rnd, e.norm}) begin
        n_fail++;
        $display("FAIL %s_result: man=%h rnd=%b norm=%b required man=%h rnd=%b norm=%b",
                 name, o_man, o_rounding_bit, o_norm_shift, e.man, e.rnd, e.norm);
      end
    end
  endtask

  task automatic run_op(input logic [S-1:0] a, input logic [S-1:0] b, input string name);
    int cyc;
    i_ready = 1'b1;
    send_op(a, b);
    wait_result(name, cyc);
    n_tests++;
    if (cyc !== S + 1) begin
      n_fail++; $display("FAIL %s_latency: %0d cycles required %0d", name, cyc, S + 1);
    end
    @(posedge i_clk); #1;
    @(negedge i_clk);
    n_tests++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_release: o_valid=%b o_ready=%b required 0 1", name, o_valid, o_ready);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #12;
    n_tests++;
    if ({o_valid, o_ready, o_man, o_rounding_bit, o_norm_shift} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b ready=%b man=%h rnd=%b norm=%b required all 0",
               o_valid, o_ready, o_man, o_rounding_bit, o_norm_shift);
    end
    @(negedge i_clk); i_rst_n = 1'b1;
    @(negedge i_clk);
    n_tests++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: o_ready=%b o_valid=%b required 1 0", o_ready, o_valid);
    end
  endtask

  // Directed vectors with constant expected outputs, also cross-checked by the scoreboard.
  task automatic test_directed();
    logic [S-1:0] ta [6] = '{24'h800000, 24'hC00000, 24'hC00000, 24'hC00000, 24'hFFFFFF, 24'h000000};
    logic [S-1:0] tb [6] = '{24'h800000, 24'hC00000, 24'h800001, 24'h800003, 24'hFFFFFF, 24'h000000};
    logic [S-1:0] tm [6] = '{24'h800000, 24'h900000, 24'hC00001, 24'hC00004, 24'hFFFFFE, 24'h000000};
    logic         tr [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic         tn [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], $sformatf("directed%0d", i));
      n_tests++;
      if ({o_man, o_rounding_bit, o_norm_shift} !== {tm[i], tr[i], tn[i]}) begin
        n_fail++;
        $display("FAIL directed%0d_const: man=%h rnd=%b norm=%b required man=%h rnd=%b norm=%b",
                 i, o_man, o_rounding_bit, o_norm_shift, tm[i], tr[i], tn[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   w;
    i_ready = 1'b0;
    send_op(24'hC00000, 24'h800001);
    e = sb.pop_front();
    w = 0;
    @(negedge i_clk);
    while (!o_valid && w < 200) begin @(negedge i_clk); w++; end
    for (int c = 0; c < 10; c++) begin
      i_man_a = 24'hFFFFFF; i_man_b = 24'h800000; i_valid = 1'b1;
      n_tests++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 ||
          {o_man, o_rounding_bit, o_norm_shift} !== {e.man, e.rnd, e.norm}) begin
        n_fail++;
        $display("FAIL stall_c%0d: valid=%b ready=%b man=%h rnd=%b norm=%b required 1 0 %h %b %b",
                 c, o_valid, o_ready, o_man, o_rounding_bit, o_norm_shift, e.man, e.rnd, e.norm);
      end
      @(negedge i_clk);
    end
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    n_tests++;
    if (o_valid !== 1'b0 || {o_man, o_rounding_bit, o_norm_shift} !== {e.man, e.rnd, e.norm}) begin
      n_fail++;
      $display("FAIL stall_hold: valid=%b man=%h required 0 %h", o_valid, o_man, e.man);
    end
    // Operands offered during the stall must not have started a new product.
    w = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      if (o_valid) w++;
    end
    n_tests++;
    if (w !== 0) begin
      n_fail++; $display("FAIL stall_ignored: %0d spurious valid cycles required 0", w);
    end
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b1;
    send_op(24'hABCDEF, 24'h923456);
    repeat (7) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_valid, o_ready, o_man, o_rounding_bit, o_norm_shift} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: valid=%b ready=%b man=%h required all 0", o_valid, o_ready, o_man);
    end
    sb.delete();
    @(negedge i_clk); i_rst_n = 1'b1;
    @(negedge i_clk);
    n_tests++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_release: o_ready=%b o_valid=%b required 1 0", o_ready, o_valid);
    end
    run_op(24'hC00000, 24'h800003, "after_reset");
  endtask

  task automatic test_random();
    logic [S-1:0] a, b;
    for (int i = 0; i < 16; i++) begin
      a = S'($urandom);
      b = S'($urandom);
      if (i % 4 != 3) begin a[S-1] = 1'b1; b[S-1] = 1'b1; end
      run_op(a, b, $sformatf("random%0d", i));
    end
  endtask

  // Continuous traffic: i_valid and i_ready held high, result spacing measured.
  task automatic test_back_to_back();
    logic [S-1:0] ta [3] = '{24'h8F0F0F, 24'hFFFFFF, 24'hC00000};
    logic [S-1:0] tb [3] = '{24'hF0F0F1, 24'h800001, 24'h800001};
    int   t [3];
    int   idx, got;
    logic hs;
    exp_t e;
    idx = 0; got = 0;
    i_ready = 1'b1;
    @(negedge i_clk);
    i_man_a = ta[0]; i_man_b = tb[0]; i_valid = 1'b1;
    for (int c = 0; c < 300 && got < 3; c++) begin
      hs = i_valid & o_ready;
      if (hs) sb.push_back(model(i_man_a, i_man_b));
      if (o_valid) begin
        e = sb.pop_front();
        n_tests++;
        if ({o_man, o_rounding_bit, o_norm_shift} !== {e.man, e.rnd, e.norm}) begin
          n_fail++;
          $display("FAIL b2b%0d_result: man=%h rnd=%b norm=%b required man=%h rnd=%b norm=%b",
                   got, o_man, o_rounding_bit, o_norm_shift, e.man, e.rnd, e.norm);
        end
        t[got] = c;
        got++;
      end
      @(posedge i_clk); #1;
      if (hs) begin
        idx++;
        if (idx < 3) begin i_man_a = ta[idx]; i_man_b = tb[idx]; end
        else i_valid = 1'b0;
      end
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    n_tests++;
    if (got !== 3) begin
      n_fail++; $display("FAIL b2b_count: %0d results required 3", got);
    end else begin
      n_tests++;
      if (t[1] - t[0] !== S + 2 || t[2] - t[1] !== S + 2) begin
        n_fail++;
        $display("FAIL b2b_period: spacing %0d,%0d required %0d", t[1] - t[0], t[2] - t[1], S + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
